alu_wb_stage: RTL and testbench
===============================

ALU_WB_STAGE -- requirements
Module: alu_wb_stage

Interface
REQ-001 The block SHALL have exactly one clock; reset SHALL be asynchronous and active-low.
REQ-002 Ports SHALL be, one per line (name  direction  width  meaning):
- clock  in  1  sole clock, rising edge
- reset  in  1  asynchronous active-low reset
- flush  in  1  synchronous discard of all held entries
- in_valid  in  1  ALU result presented
- in_ready  out  1  stage can accept
- in_result  in  32  ALU data_result
- in_overflow  in  1  ALU overflow
- in_isNotEqual  in  1  ALU isNotEqual
- in_isLessThan  in  1  ALU isLessThan
- in_rd  in  5  destination register
- in_kind  in  2  00 other, 01 add, 10 addi, 11 sub
- out_valid  out  1  writeback entry available
- out_ready  in  1  consumer takes entry
- out_wren  out  1  register-file write enable
- out_rd  out  5  write address
- out_data  out  32  write data
- out_isNotEqual  out  1  forwarded flag
- out_isLessThan  out  1  forwarded flag
- exc_count  out  8  saturating overflow-exception count

Function
REQ-003 The block SHALL buffer up to 2 entries in FIFO order (skid buffer) with occupancy states EMPTY, ONE, FULL.
REQ-004 in_ready SHALL be 1 in EMPTY and ONE and 0 in FULL; it SHALL depend only on registered state.
REQ-005 A push SHALL occur when in_valid and in_ready; a pop SHALL occur when out_valid and out_ready.
REQ-006 out_valid SHALL be 1 exactly when occupancy is not EMPTY; out_* SHALL show the oldest entry.
REQ-007 Latency SHALL be 1 cycle: an entry pushed at edge N is visible on out_* after edge N.
REQ-008 State transitions: EMPTY->ONE on push; ONE->FULL on push without pop; ONE->EMPTY on pop without push; ONE stays ONE on simultaneous push and pop; FULL->ONE on pop.
REQ-009 Exception rewrite at push: if in_overflow=1 and in_kind!=00, the entry SHALL be stored with rd=30, wren=1, data=1 (add), 2 (addi), 3 (sub).
REQ-010 Otherwise the entry SHALL store rd=in_rd, data=in_result, wren=0 when in_rd=0, else wren=1.
REQ-011 in_overflow with in_kind=00 SHALL be ignored (no rewrite, no count).
REQ-012 Flags SHALL pass through unchanged with their entry.
REQ-013 exc_count SHALL increment by 1 per pushed rewritten entry and saturate at 255.
REQ-014 flush=1 SHALL set occupancy to EMPTY at the next edge, overriding any push or pop that cycle; exc_count SHALL be unaffected.
REQ-015 Pushes when in_ready=0 SHALL be ignored with no state change; pops when EMPTY SHALL be ignored.

Reset
REQ-016 While reset=0: occupancy EMPTY, out_valid=0, out_wren=0, out_rd=0, out_data=0, flags=0, exc_count=0, in_ready=1.
REQ-017 Reset asserted mid-transfer SHALL discard all entries immediately, without waiting for a clock edge.

Structure
REQ-018 Shared package alu_wb_pkg SHALL hold the kind encodings, RSTATUS_REG=30, the status codes 1/2/3, and DEPTH=2.
REQ-019 The rewrite logic SHALL be the sub-module wb_exc_rewrite (combinational, kind/overflow/rd/result -> rd/data/wren/exc).

Verification
REQ-020 add overflow: push result=0x80000000, overflow=1, kind=01, rd=5 -> next cycle out_rd=30, out_data=1, out_wren=1, exc_count=1.
REQ-021 Fill and back-pressure: out_ready=0, push rd=3 then rd=4 -> in_ready=0; third push ignored; out_ready=1 -> rd 3 then rd 4 emitted in order.
REQ-022 Simultaneous push and pop in ONE: occupancy stays ONE; sub overflow entry emitted with out_data=3.
REQ-023 rd=0, no overflow, result=0x1234 -> out_wren=0; kind=00 with overflow=1 -> no rewrite, exc_count unchanged.
REQ-024 FULL plus flush=1 with in_valid=1 -> out_valid=0 next cycle, new entry not stored; 256 rewritten pushes -> exc_count=255.
REQ-025 reset=0 asserted between edges while FULL -> out_valid=0 before the next edge; all outputs at REQ-016 values.

Source files
------------

// File: rtl/alu_wb_pkg.sv
// alu_wb_pkg: shared encodings and types for the
// ALU writeback skid-buffer stage.
package alu_wb_pkg;

  localparam logic [1:0] KIND_OTHER = 2'b00;
  localparam logic [1:0] KIND_ADD   = 2'b01;
  localparam logic [1:0] KIND_ADDI  = 2'b10;
  localparam logic [1:0] KIND_SUB   = 2'b11;

  localparam logic [4:0] RSTATUS_REG = 5'd30;

  localparam logic [31:0] ST_ADD  = 32'd1;
  localparam logic [31:0] ST_ADDI = 32'd2;
  localparam logic [31:0] ST_SUB  = 32'd3;

  localparam int DEPTH = 2;

  localparam logic [7:0] EXC_MAX = 8'hFF;

  typedef enum logic [1:0] {
    EMPTY,
    ONE,
    FULL
  } occ_e;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
    logic        wren;
    logic        ne;
    logic        lt;
  } wb_entry_t;

endpackage

// File: rtl/wb_exc_rewrite.sv
// wb_exc_rewrite: turns an overflowing arithmetic
// result into a status write to RSTATUS_REG.
module wb_exc_rewrite
  import alu_wb_pkg::*;
(
  input  logic [1:0]  kind_i,
  input  logic        overflow_i,
  input  logic [4:0]  rd_i,
  input  logic [31:0] result_i,
  output logic [4:0]  rd_o,
  output logic [31:0] data_o,
  output logic        wren_o,
  output logic        exc_o
);

  always_comb begin
    rd_o   = rd_i;
    data_o = result_i;
    wren_o = (rd_i != 5'd0);
    exc_o  = 1'b0;
    if (overflow_i && (kind_i != KIND_OTHER)) begin
      exc_o  = 1'b1;
      rd_o   = RSTATUS_REG;
      wren_o = 1'b1;
      unique case (1'b1)
        (kind_i == KIND_ADD):  data_o = ST_ADD;
        (kind_i == KIND_ADDI): data_o = ST_ADDI;
        default:               data_o = ST_SUB;
      endcase
    end
  end

endmodule

// File: rtl/alu_wb_stage.sv
// alu_wb_stage: two-entry skid buffer between the ALU
// and register-file writeback, with overflow rewrite.
module alu_wb_stage
  import alu_wb_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_result,
  input  logic        in_overflow,
  input  logic        in_isNotEqual,
  input  logic        in_isLessThan,
  input  logic [4:0]  in_rd,
  input  logic [1:0]  in_kind,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_wren,
  output logic [4:0]  out_rd,
  output logic [31:0] out_data,
  output logic        out_isNotEqual,
  output logic        out_isLessThan,
  output logic [7:0]  exc_count
);

  occ_e       state_q, state_d;
  wb_entry_t  slots_q [DEPTH];
  wb_entry_t  slots_d [DEPTH];
  logic [7:0] cnt_q, cnt_d;

  wb_entry_t  new_e;
  logic       new_exc;
  logic       push, pop;

  wb_exc_rewrite u_rewrite (
    .kind_i     (in_kind),
    .overflow_i (in_overflow),
    .rd_i       (in_rd),
    .result_i   (in_result),
    .rd_o       (new_e.rd),
    .data_o     (new_e.data),
    .wren_o     (new_e.wren),
    .exc_o      (new_exc)
  );

  assign new_e.ne = in_isNotEqual;
  assign new_e.lt = in_isLessThan;

  assign in_ready  = (state_q != FULL);
  assign out_valid = (state_q != EMPTY);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // slot 0 is always the oldest entry
  assign out_rd         = slots_q[0].rd;
  assign out_data       = slots_q[0].data;
  assign out_wren       = slots_q[0].wren;
  assign out_isNotEqual = slots_q[0].ne;
  assign out_isLessThan = slots_q[0].lt;
  assign exc_count      = cnt_q;

  always_comb begin
    state_d    = state_q;
    slots_d[0] = slots_q[0];
    slots_d[1] = slots_q[1];
    cnt_d      = cnt_q;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (push) begin
            slots_d[0] = new_e;
            state_d    = ONE;
          end
        end
        ONE: begin
          if (push && pop) begin
            slots_d[0] = new_e;
          end else if (push) begin
            slots_d[1] = new_e;
            state_d    = FULL;
          end else if (pop) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (pop) begin
            slots_d[0] = slots_q[1];
            state_d    = ONE;
          end
        end
        default: state_d = EMPTY;
      endcase
      if (push && new_exc && (cnt_q != EXC_MAX))
        cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= EMPTY;
      cnt_q   <= '0;
      for (int i = 0; i < DEPTH; i++)
        slots_q[i] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      for (int i = 0; i < DEPTH; i++)
        slots_q[i] <= slots_d[i];
    end
  end

endmodule

// File: tb/tb_alu_wb_stage.sv
// tb_alu_wb_stage: vector table, corner sequences and
// randomized run against a queue-based model.
module tb_alu_wb_stage;

  logic        clock = 1'b0;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_result;
  logic        in_overflow;
  logic        in_isNotEqual;
  logic        in_isLessThan;
  logic [4:0]  in_rd;
  logic [1:0]  in_kind;
  logic        out_valid;
  logic        out_ready;
  logic        out_wren;
  logic [4:0]  out_rd;
  logic [31:0] out_data;
  logic        out_isNotEqual;
  logic        out_isLessThan;
  logic [7:0]  exc_count;

  int checks = 0;
  int failures = 0;
  int cnt_m;

  alu_wb_stage dut (
    .clock          (clock),
    .reset          (reset),
    .flush          (flush),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_result      (in_result),
    .in_overflow    (in_overflow),
    .in_isNotEqual  (in_isNotEqual),
    .in_isLessThan  (in_isLessThan),
    .in_rd          (in_rd),
    .in_kind        (in_kind),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_wren       (out_wren),
    .out_rd         (out_rd),
    .out_data       (out_data),
    .out_isNotEqual (out_isNotEqual),
    .out_isLessThan (out_isLessThan),
    .exc_count      (exc_count)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [1:0]  kind;
    logic        ovf;
    logic [4:0]  rd;
    logic [31:0] res;
    logic        ne;
    logic        lt;
    logic [4:0]  erd;
    logic [31:0] edata;
    logic        ewren;
    int          einc;
  } vec_t;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
    logic        wren;
    logic        ne;
    logic        lt;
  } ment_t;

  vec_t  vt[6];
  ment_t q[$];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h",
               nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic [1:0] k,
                       input logic o,
                       input logic [4:0] r,
                       input logic [31:0] d,
                       input logic ne,
                       input logic lt);
    in_valid      = 1'b1;
    in_kind       = k;
    in_overflow   = o;
    in_rd         = r;
    in_result     = d;
    in_isNotEqual = ne;
    in_isLessThan = lt;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_out_valid"}, 32'(out_valid), 0);
    chk({tag, "_in_ready"}, 32'(in_ready), 1);
    chk({tag, "_out_wren"}, 32'(out_wren), 0);
    chk({tag, "_out_rd"}, 32'(out_rd), 0);
    chk({tag, "_out_data"}, out_data, 0);
    chk({tag, "_flags"},
        {30'd0, out_isNotEqual, out_isLessThan}, 0);
    chk({tag, "_exc"}, 32'(exc_count), 0);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #2;
    @(negedge clock);
    reset = 1'b1;
    cnt_m = 0;
    q.delete();
    step();
  endtask

  function automatic ment_t model_entry(
      input logic [1:0] k, input logic o,
      input logic [4:0] r, input logic [31:0] d,
      input logic ne, input logic lt);
    ment_t e;
    e.ne = ne;
    e.lt = lt;
    if (o && k != 0) begin
      e.rd   = 30;
      e.data = 32'(k);
      e.wren = 1'b1;
    end else begin
      e.rd   = r;
      e.data = d;
      e.wren = (r != 0);
    end
    return e;
  endfunction

  initial begin
    vt[0] = '{2'b01, 1, 5'd5, 32'h8000_0000, 1, 0,
              5'd30, 32'd1, 1, 1};
    vt[1] = '{2'b10, 1, 5'd9, 32'h7FFF_FFFF, 0, 1,
              5'd30, 32'd2, 1, 1};
    vt[2] = '{2'b11, 1, 5'd0, 32'h0000_0001, 1, 1,
              5'd30, 32'd3, 1, 1};
    vt[3] = '{2'b00, 1, 5'd12, 32'hDEAD_BEEF, 0, 0,
              5'd12, 32'hDEAD_BEEF, 1, 0};
    vt[4] = '{2'b01, 0, 5'd0, 32'h0000_1234, 1, 0,
              5'd0, 32'h0000_1234, 0, 0};
    vt[5] = '{2'b11, 0, 5'd31, 32'hCAFE_0001, 0, 1,
              5'd31, 32'hCAFE_0001, 1, 0};

    reset = 1'b0;
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    in_valid = 1'b0;
    #3;
    chk_reset_vals("rst");
    @(negedge clock);
    reset = 1'b1;
    cnt_m = 0;
    step();

    foreach (vt[i]) begin
      drive(vt[i].kind, vt[i].ovf, vt[i].rd,
            vt[i].res, vt[i].ne, vt[i].lt);
      out_ready = 1'b0;
      step();
      in_valid = 1'b0;
      cnt_m += vt[i].einc;
      chk($sformatf("vec%0d_valid", i),
          32'(out_valid), 1);
      chk($sformatf("vec%0d_rd", i),
          32'(out_rd), 32'(vt[i].erd));
      chk($sformatf("vec%0d_data", i),
          out_data, vt[i].edata);
      chk($sformatf("vec%0d_wren", i),
          32'(out_wren), 32'(vt[i].ewren));
      chk($sformatf("vec%0d_flags", i),
          {30'd0, out_isNotEqual, out_isLessThan},
          {30'd0, vt[i].ne, vt[i].lt});
      chk($sformatf("vec%0d_exc", i),
          32'(exc_count), 32'(cnt_m));
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      chk($sformatf("vec%0d_drain", i),
          32'(out_valid), 0);
    end

    out_ready = 1'b0;
    drive(2'b01, 0, 5'd3, 32'h33, 0, 0);
    step();
    drive(2'b01, 0, 5'd4, 32'h44, 0, 0);
    step();
    chk("bp_in_ready_full", 32'(in_ready), 0);
    drive(2'b01, 0, 5'd9, 32'h99, 0, 0);
    step();
    in_valid = 1'b0;
    chk("bp_third_ignored", 32'(out_rd), 3);
    out_ready = 1'b1;
    step();
    chk("bp_second_rd", 32'(out_rd), 4);
    chk("bp_second_data", out_data, 32'h44);
    step();
    chk("bp_empty", 32'(out_valid), 0);
    out_ready = 1'b0;

    drive(2'b01, 0, 5'd6, 32'h66, 0, 0);
    step();
    drive(2'b11, 1, 5'd7, 32'h77, 1, 0);
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    cnt_m++;
    chk("pp_valid", 32'(out_valid), 1);
    chk("pp_ready", 32'(in_ready), 1);
    chk("pp_data", out_data, 3);
    chk("pp_rd", 32'(out_rd), 30);
    chk("pp_exc", 32'(exc_count), 32'(cnt_m));
    step();
    chk("pp_was_one", 32'(out_valid), 0);
    out_ready = 1'b0;

    drive(2'b01, 0, 5'd1, 32'h1, 0, 0);
    step();
    drive(2'b01, 0, 5'd2, 32'h2, 0, 0);
    step();
    drive(2'b01, 0, 5'd11, 32'hB, 0, 0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("fl_full_valid", 32'(out_valid), 0);
    chk("fl_full_ready", 32'(in_ready), 1);
    drive(2'b01, 0, 5'd13, 32'hD, 0, 0);
    step();
    drive(2'b01, 0, 5'd14, 32'hE, 0, 0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("fl_one_push_dropped", 32'(out_valid), 0);
    chk("fl_exc_kept", 32'(exc_count), 32'(cnt_m));

    out_ready = 1'b1;
    drive(2'b01, 1, 5'd1, 32'h0, 0, 0);
    repeat (256) step();
    in_valid = 1'b0;
    chk("sat_255", 32'(exc_count), 255);
    drive(2'b10, 1, 5'd1, 32'h0, 0, 0);
    step();
    in_valid = 1'b0;
    chk("sat_hold", 32'(exc_count), 255);
    out_ready = 1'b0;

    do_reset();
    drive(2'b01, 0, 5'd21, 32'h21, 1, 1);
    step();
    drive(2'b01, 1, 5'd22, 32'h22, 1, 1);
    step();
    in_valid = 1'b0;
    chk("ar_full", 32'(in_ready), 0);
    #2;
    reset = 1'b0;
    #1;
    chk_reset_vals("ar");
    do_reset();

    for (int c = 0; c < 600; c++) begin
      logic iv, orr, fl, ov;
      logic [1:0] k;
      logic [4:0] r;
      logic [31:0] d;
      logic ne, lt;
      logic push, pop;
      ment_t e;
      iv  = ($urandom_range(0, 3) != 0);
      orr = ($urandom_range(0, 2) != 0);
      fl  = ($urandom_range(0, 19) == 0);
      ov  = fl ? 1'b0 : ($urandom_range(0, 3) == 0);
      k   = 2'($urandom_range(0, 3));
      r   = ($urandom_range(0, 4) == 0) ? 5'd0
                                        : 5'($urandom);
      d   = $urandom;
      ne  = 1'($urandom);
      lt  = 1'($urandom);
      drive(k, ov, r, d, ne, lt);
      in_valid  = iv;
      out_ready = orr;
      flush     = fl;
      chk("rnd_in_ready", 32'(in_ready),
          32'(q.size() < 2));
      chk("rnd_out_valid", 32'(out_valid),
          32'(q.size() != 0));
      chk("rnd_exc", 32'(exc_count), 32'(cnt_m));
      if (q.size() != 0) begin
        chk("rnd_rd", 32'(out_rd), 32'(q[0].rd));
        chk("rnd_data", out_data, q[0].data);
        chk("rnd_wren", 32'(out_wren),
            32'(q[0].wren));
        chk("rnd_flags",
            {30'd0, out_isNotEqual, out_isLessThan},
            {30'd0, q[0].ne, q[0].lt});
      end
      push = iv && (q.size() < 2);
      pop  = orr && (q.size() != 0);
      if (fl) begin
        q.delete();
      end else begin
        if (pop) void'(q.pop_front());
        if (push) begin
          e = model_entry(k, ov, r, d, ne, lt);
          q.push_back(e);
          if (ov && k != 0 && cnt_m < 255) cnt_m++;
        end
      end
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
